fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be:
- XLEN, 64, PC/address width.
- RESET_VECTOR, 0, first fetch address.
- FIFO_DEPTH, 4, fetch-buffer entries; power of two, >=2.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  instruction-memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  response valid, one cycle, in order.
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts entry.
- out_pc  out  XLEN  PC of presented instruction.
- out_instr  out  32  presented instruction.

Function
REQ-003 fetch_pc register SHALL drive imem_req_addr; bits [1:0] SHALL always be 0.
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DISCARD.
REQ-005 IDLE -> REQ on the first clk edge after reset deasserts.
REQ-006 In REQ, imem_req_valid=1 only when count+1 <= FIFO_DEPTH (credit check); otherwise 0 and stay in REQ.
REQ-007 REQ with valid&ready SHALL go to WAIT, latch issued PC, set fetch_pc = fetch_pc+4 (mod 2^XLEN).
REQ-008 In REQ, imem_req_addr SHALL change while valid is high only due to a redirect.
REQ-009 WAIT with imem_rsp_valid SHALL push {issued PC, imem_rsp_data} into the buffer and go to REQ.
REQ-010 At most one request SHALL be outstanding.
REQ-011 out_valid = buffer non-empty; out_pc/out_instr = head entry; pop on out_valid&out_ready.
REQ-012 Simultaneous push and pop SHALL keep count unchanged; no overflow SHALL occur due to REQ-006.
REQ-013 Redirect SHALL, in the same edge:
- flush the buffer;
- set fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
REQ-014 Redirect priority over other events:
- over pop: the popped entry is discarded, and out_* on the redirect cycle SHALL be ignored by decode;
- over push: a response arriving in the redirect cycle SHALL be dropped.
REQ-015 Redirect next state:
- in WAIT, or in REQ with request accepted that cycle: DISCARD;
- otherwise: REQ.
REQ-016 DISCARD SHALL drop the next imem_rsp_valid without pushing and go to REQ; a further redirect in DISCARD SHALL only update fetch_pc.
REQ-017 fetch_pc wrap from 2^XLEN-4 SHALL yield 0.

Reset
REQ-018 reset low SHALL asynchronously force:
- state = IDLE;
- fetch_pc = RESET_VECTOR with [1:0] cleared;
- buffer count and pointers = 0;
- imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-019 A response arriving after reset mid-WAIT SHALL be ignored (IDLE does not accept responses).

Structure
REQ-020 Shared package fetch_pkg SHALL hold:
- state enum;
- ILEN=32;
- PC_INCR=4.
REQ-021 The buffer SHALL be sub-module fetch_fifo:
- synchronous FIFO, parameters WIDTH/DEPTH;
- flush input;
- count output.
REQ-022 fetch_unit SHALL contain only the FSM, fetch_pc, credit logic and one fetch_fifo instance.

Verification
REQ-023 Reset release, ready=1, rsp one cycle later, out_ready=1:
- addresses SHALL be 0x0, 0x4, 0x8;
- out_pc SHALL match, in order.
REQ-024 out_ready=0 with FIFO_DEPTH=4:
- after 4 entries, imem_req_valid SHALL stay 0;
- one pop SHALL re-enable exactly one request.
REQ-025 Redirect to 0x1003 while in WAIT:
- buffer SHALL empty;
- the next response SHALL be discarded;
- next request address SHALL be 0x1000.
REQ-026 Redirect coincident with pop and response:
- count SHALL be 0 next cycle;
- out_valid SHALL be 0.
REQ-027 XLEN=32, redirect to 0xFFFFFFFC:
- requests SHALL be 0xFFFFFFFC then 0x00000000.
REQ-028 reset asserted mid-WAIT:
- outputs SHALL be at reset values immediately, without a clock edge;
- a late rsp_valid SHALL push nothing.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: power-of-two ring with occupancy count and flush.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign do_push_s = push_i & ~full_s;
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage, pointers and count; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, credit-checked
// against a small buffer that feeds decode; redirects flush and retarget fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN         = 64,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int unsigned       FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [ILEN-1:0]   imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_instr
);

  localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     EW         = XLEN + ILEN;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'd3));

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issued_pc_q, issued_pc_d;
  logic [XLEN-1:0] fetch_pc_seq_s;
  logic [XLEN-1:0] redirect_tgt_s;
  logic [CW-1:0]   fifo_count_s;
  logic            credit_ok_s;
  logic            req_valid_s;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;
  logic [EW-1:0]   head_s;

  assign redirect_tgt_s = redirect_pc & ALIGN_MASK;
  assign credit_ok_s    = (fifo_count_s < CW'(FIFO_DEPTH));
  assign pop_s          = ~empty_s & out_ready;

  // State, fetch PC and the PC of the request currently in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_VECTOR & ALIGN_MASK;
      issued_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  // Next-state, request and push decisions; a redirect overrides the sequential PC.
  always_comb begin
    state_d        = state_q;
    issued_pc_d    = issued_pc_q;
    fetch_pc_seq_s = fetch_pc_q;
    req_valid_s    = 1'b0;
    push_s         = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        req_valid_s = credit_ok_s;
        if (credit_ok_s && imem_req_ready) begin
          issued_pc_d    = fetch_pc_q;
          fetch_pc_seq_s = fetch_pc_q + XLEN'(PC_INCR);
          state_d        = redirect_valid ? DISCARD : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        // A response landing with a redirect is the one we would discard, so no DISCARD detour.
        if (imem_rsp_valid) begin
          push_s  = ~redirect_valid;
          state_d = REQ;
        end else begin
          state_d = redirect_valid ? DISCARD : WAIT;
        end
      end
      DISCARD: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    fetch_pc_d = redirect_valid ? redirect_tgt_s : fetch_pc_seq_s;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (redirect_valid),
    .push_i      (push_s),
    .push_data_i ({issued_pc_q, imem_rsp_data}),
    .pop_i       (pop_s),
    .head_data_o (head_s),
    .empty_o     (empty_s),
    .count_o     (fifo_count_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = ~empty_s;
  assign out_pc         = head_s[EW-1:ILEN];
  assign out_instr      = head_s[ILEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios queue expected requests and
// decode entries; a negedge monitor pops and compares whatever the DUT presents.
module tb_fetch_unit;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_t;

  logic            clk;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  logic [31:0] exp_req_q[$];
  out_t        exp_out_q[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          limit = 0;
  logic        acc_now = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        pend_v = 1'b0;
  logic [31:0] pend_a = 32'h0;
  logic        hold = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_both(input logic [31:0] a);
    exp_req_q.push_back(a);
    exp_out_q.push_back('{pc: a, instr: instr_of(a)});
  endtask

  // Advance one cycle; memory model answers one cycle after acceptance unless held.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_now) begin
      pend_v = 1'b1;
      pend_a = acc_addr;
    end
    if (pend_v && !hold) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_a);
      pend_v         = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = (n_acc < limit);
  endtask

  task automatic start_test();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    hold           = 1'b0;
    pend_v         = 1'b0;
    limit          = n_acc;
    #1;
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_pc", {32'h0, out_pc}, 64'h0);
    chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (n_acc < n && k < 60) begin
      step();
      k++;
    end
    if (n_acc < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_acc: got %0d accepted, expected %0d", n_acc, n);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_req_q.size() != 0 || exp_out_q.size() != 0) && k < 80) begin
      step();
      k++;
    end
    chk({name, "_req_left"}, 64'(exp_req_q.size()), 64'h0);
    chk({name, "_out_left"}, 64'(exp_out_q.size()), 64'h0);
    exp_req_q.delete();
    exp_out_q.delete();
  endtask

  // Monitor: sample mid-cycle, score accepted requests and consumed entries.
  initial begin
    logic [31:0] e;
    out_t        eo;
    forever begin
      @(negedge clk);
      acc_now  = reset && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      if (acc_now) begin
        n_acc++;
        if (exp_req_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h, expected none", imem_req_addr);
        end else begin
          e = exp_req_q.pop_front();
          chk("req_addr", {32'h0, imem_req_addr}, {32'h0, e});
        end
      end
      if (reset && out_valid && out_ready && !redirect_valid) begin
        if (exp_out_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_unexpected: got pc %h instr %h, expected none", out_pc, out_instr);
        end else begin
          eo = exp_out_q.pop_front();
          chk("out_pc", {32'h0, out_pc}, {32'h0, eo.pc});
          chk("out_instr", {32'h0, out_instr}, {32'h0, eo.instr});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;

    // Streaming: addresses 0,4,8 and matching decode entries in order.
    start_test();
    base = n_acc;
    out_ready = 1'b1;
    limit = base + 3;
    exp_both(32'h0000_0000);
    exp_both(32'h0000_0004);
    exp_both(32'h0000_0008);
    drain("stream");

    // Back-pressure: four entries stop requests; one pop reopens exactly one.
    start_test();
    base = n_acc;
    limit = base + 6;
    exp_req_q.push_back(32'h0000_0000);
    exp_req_q.push_back(32'h0000_0004);
    exp_req_q.push_back(32'h0000_0008);
    exp_req_q.push_back(32'h0000_000C);
    repeat (30) step();
    chk("full_acc", 64'(n_acc - base), 64'd4);
    chk("full_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("full_out_valid", {63'h0, out_valid}, 64'h1);
    exp_out_q.push_back('{pc: 32'h0, instr: instr_of(32'h0)});
    exp_req_q.push_back(32'h0000_0010);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (20) step();
    chk("one_more_acc", 64'(n_acc - base), 64'd5);
    chk("refull_req_valid", {63'h0, imem_req_valid}, 64'h0);
    drain("credit");

    // Redirect to 0x1003 while waiting: flush, drop late response, resume at 0x1000.
    start_test();
    base = n_acc;
    limit = base + 3;
    exp_req_q.push_back(32'h0000_0000);
    exp_req_q.push_back(32'h0000_0004);
    exp_req_q.push_back(32'h0000_0008);
    wait_acc(base + 2);
    hold = 1'b1;
    wait_acc(base + 3);
    chk("pre_redir_out_valid", {63'h0, out_valid}, 64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    step();
    redirect_valid = 1'b0;
    chk("flushed_out_valid", {63'h0, out_valid}, 64'h0);
    chk("discard_req_valid", {63'h0, imem_req_valid}, 64'h0);
    hold = 1'b0;
    out_ready = 1'b1;
    limit = n_acc + 2;
    exp_both(32'h0000_1000);
    exp_both(32'h0000_1004);
    drain("redir_wait");

    // Redirect coincident with a pop and an arriving response.
    start_test();
    base = n_acc;
    limit = base + 2;
    exp_req_q.push_back(32'h0000_0000);
    exp_req_q.push_back(32'h0000_0004);
    wait_acc(base + 2);
    chk("coinc_rsp_valid", {63'h0, imem_rsp_valid}, 64'h1);
    chk("coinc_out_valid", {63'h0, out_valid}, 64'h1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    chk("coinc_after_out_valid", {63'h0, out_valid}, 64'h0);
    limit = n_acc + 1;
    exp_both(32'h0000_2000);
    drain("redir_coinc");

    // Address wrap: 0xFFFFFFFC then 0x00000000.
    start_test();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    limit = n_acc + 2;
    exp_both(32'hFFFF_FFFC);
    exp_both(32'h0000_0000);
    drain("wrap");

    // Reset mid-wait: immediate reset values, late response ignored.
    start_test();
    base = n_acc;
    limit = base + 2;
    exp_req_q.push_back(32'h0000_0000);
    exp_req_q.push_back(32'h0000_0004);
    wait_acc(base + 1);
    hold = 1'b1;
    wait_acc(base + 2);
    chk("pre_rst_out_instr", {32'h0, out_instr}, {32'h0, instr_of(32'h0)});
    #2;
    reset = 1'b0;
    #1;
    chk("async_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("async_out_valid", {63'h0, out_valid}, 64'h0);
    chk("async_out_pc", {32'h0, out_pc}, 64'h0);
    chk("async_out_instr", {32'h0, out_instr}, 64'h0);
    hold = 1'b0;
    out_ready = 1'b1;
    limit = n_acc + 2;
    exp_both(32'h0000_0000);
    exp_both(32'h0000_0004);
    step();
    reset = 1'b1;
    drain("late_rsp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
